// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive front end.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous input; resets to the idle-high level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Framed serial byte receiver: start, 8 data bits LSB-first, parity, stop.
// Reports parity and framing errors alongside each received byte.
module serial_parity_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] shreg;
  logic par_bit;
  logic rx_s;
  logic shift_en, par_en, stop_en;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bitcnt     <= bitcnt_n;
      data_valid <= stop_en;
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (par_en) par_bit <= rx_s;
      if (stop_en) begin
        data_out   <= shreg;
        parity_err <= ((^shreg) ^ par_bit) != PARITY_ODD;
        frame_err  <= ~rx_s;
      end
    end
  end

  // Baud counter wraps to zero at every sample point, so one compare per state suffices.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n    = '0;
        bitcnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == MID) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n    = '0;
          shift_en = 1'b1;
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) state_n = PARITY;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          par_en  = 1'b1;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          stop_en = 1'b1;
          state_n = rx_s ? IDLE : WAIT_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
Serial front end that feeds the 8-bit parity checker. It recovers framed bytes from a single asynchronous serial line and presents each byte with a one-cycle valid strobe. It also re-checks the transmitted parity bit and reports parity and framing errors. Downstream logic consumes data_out/data_valid directly.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit period; must be an even value ≥ 4.
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
rx  input  1  serial line, idle high; asynchronous to clk.
data_out  output  8  last received byte, LSB = first data bit received.
data_valid  output  1  one-cycle pulse when a frame completes.
parity_err  output  1  parity mismatch for the current data_out; valid while data_valid = 1, held until the next frame.
frame_err  output  1  stop bit sampled low for the current data_out; valid/held as parity_err.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low. On reset, all outputs = 0, state = IDLE, counters = 0, synchroniser flops = 1.
- rx passes through a 2-flop synchroniser (rx_s), giving 2 cycles of latency. All decisions use rx_s.
- Frame format: start (0), 8 data bits LSB-first, parity bit, stop (1). Total 11 bit periods.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE → START: on the first cycle rx_s = 0. The baud counter clears.
- START: sample when the counter reaches CLKS_PER_BIT/2−1 (mid-bit).
  - rx_s = 1 → false start; return to IDLE with no outputs.
  - rx_s = 0 → go to DATA; the counter clears.
- DATA: sample every CLKS_PER_BIT cycles, at counter = CLKS_PER_BIT−1. Shift right into an 8-bit shift register (new bit enters bit 7). After the 8th sample, go to PARITY.
- PARITY: one sample; store the parity bit; go to STOP.
- STOP: one sample, then:
  - data_out ← shift register.
  - parity_err ← (^data XOR parity_bit) != PARITY_ODD.
  - frame_err ← ~rx_s.
  - data_valid = 1 for exactly the next clock cycle.
  - If rx_s = 1 → IDLE; otherwise → WAIT_IDLE.
- WAIT_IDLE: stay until rx_s = 1, then go to IDLE. This prevents a held-low line (break) from being decoded as a new start.
- Latency: data_valid rises 1 clock after the stop-bit sample point. That is (CLKS_PER_BIT/2) + 10·CLKS_PER_BIT + 2 (sync) + 1 cycles after the falling edge on rx.
- Back-to-back: a start edge is accepted on the cycle after returning to IDLE. A data_valid pulse coincident with the next frame's start detection is legal.
- data_out, parity_err and frame_err change only on a data_valid cycle. They hold otherwise.
- Reset asserted mid-frame: the partial byte is discarded; no data_valid; outputs clear immediately.
- Baud counter width: $clog2(CLKS_PER_BIT). It wraps to 0 at every sample point; no overflow is possible.

Decomposition:
- Shared package serial_pkg:
  - state enumeration localparams: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, WAIT_IDLE = 5; 3-bit encoding.
  - DATA_BITS = 8.
  - FRAME_BITS = 11.
- One natural sub-module: sync_2ff (2-flop synchroniser, reset value 1). Reused by any other asynchronous input in the design.
- The parity computation stays inline as an XOR reduction. No separate checker instance.

Test Plan:
- Even parity, CLKS_PER_BIT = 16. Send 0xA5 with parity bit 0 and stop 1. Expected: one data_valid pulse, data_out = 0xA5, parity_err = 0, frame_err = 0, busy low afterwards.
- Send 0xA5 with parity bit 1. Expected: data_out = 0xA5, parity_err = 1, frame_err = 0. Then send 0x01 with parity bit 1 (correct). Expected: parity_err returns to 0.
- Send 0x3C with a correct parity bit (0) and stop bit 0, then hold rx low for 40 cycles before releasing. Expected: data_out = 0x3C, frame_err = 1, exactly one data_valid, no second frame decoded during the low period.
- Pulse rx low for 3 cycles, then return high (glitch shorter than half a bit). Expected: busy pulses, returns to IDLE, data_valid never asserts.
- Back-to-back frames 0x00 then 0xFF, both with parity 0, with no idle gap. Expected: two data_valid pulses exactly 11·16 cycles apart, data 0x00 then 0xFF, no errors.
- Assert rst_n low for 1 cycle in the middle of the DATA state of frame 0x5A, then send 0x5A cleanly. Expected: no valid pulse for the aborted frame; the next frame yields data_out = 0x5A with no errors.
